// File: rtl/core_run_ctrl_if.sv
// Board/core-side signal bundle for core_run_ctrl: button, run switch, PC/breakpoint
// inputs, and the clock-enable plus status outputs.
interface core_run_ctrl_if #(
  parameter int CNT_W = 32
);
  // Advance semantics: the core consumes one instruction in every cycle where
  // o_core_en is 1; that instruction counts as retired only if i_insn_vld is also 1.
  logic              i_step_btn_n;
  logic              i_run_sw;
  logic [31:0]       i_pc;
  logic              i_insn_vld;
  logic              i_bkpt_en;
  logic [31:0]       i_bkpt_addr;
  logic              o_core_en;
  logic              o_halted;
  logic [1:0]        o_state;
  logic [CNT_W-1:0]  o_insn_cnt;

  modport master (
    output i_step_btn_n, i_run_sw, i_pc, i_insn_vld, i_bkpt_en, i_bkpt_addr,
    input  o_core_en, o_halted, o_state, o_insn_cnt
  );

  modport slave (
    input  i_step_btn_n, i_run_sw, i_pc, i_insn_vld, i_bkpt_en, i_bkpt_addr,
    output o_core_en, o_halted, o_state, o_insn_cnt
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Run/step/breakpoint sequencer producing the core clock-enable for the DE2 core.
// Define RUN_CTRL_BKPT_EN to build the PC breakpoint comparator and BREAK state.
module core_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 1,
  parameter int CNT_W           = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  core_run_ctrl_if.slave  bus
);
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    STEP  = 2'd1,
    RUN   = 2'd2,
    BREAK = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              btn_s1, btn_s2;
  logic              run_s1, run_s2;
  logic              deb_level, deb_prev;
  logic [DB_W-1:0]   deb_cnt;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  insn_cnt;
  logic              press;
  logic              div_tick;
  logic              bkpt_hit;
  logic              core_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
    end else begin
      btn_s1 <= bus.i_step_btn_n;
      btn_s2 <= btn_s1;
      run_s1 <= bus.i_run_sw;
      run_s2 <= run_s1;
    end
  end

  // The level flips on the DEBOUNCE_CYCLES-th consecutive sample that disagrees with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      deb_level <= 1'b1;
      deb_prev  <= 1'b1;
      deb_cnt   <= '0;
    end else begin
      deb_prev <= deb_level;
      if (btn_s2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_level <= btn_s2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DB_W'(1);
      end
    end
  end

  assign press = deb_prev & ~deb_level;

`ifdef RUN_CTRL_BKPT_EN
  assign bkpt_hit = bus.i_bkpt_en & (bus.i_pc == bus.i_bkpt_addr);
`else
  logic unused_bkpt;
  assign unused_bkpt = ^{bus.i_bkpt_en, bus.i_bkpt_addr, bus.i_pc};
  assign bkpt_hit    = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div <= '0;
    end else if (state != RUN) begin
      div <= '0;
    end else if (div == DIV_W'(RUN_DIV - 1)) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign div_tick = (div == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= HALT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HALT:  if (run_s2) state_nxt = RUN;
             else if (press) state_nxt = STEP;
      STEP:  state_nxt = HALT;
      RUN:   if (!run_s2) state_nxt = HALT;
             else if (bkpt_hit && div_tick) state_nxt = BREAK;
      BREAK: if (!run_s2) state_nxt = HALT;
             else if (press) state_nxt = STEP;
      default: state_nxt = HALT;
    endcase
  end

  // Breakpoint instruction is held back on the tick that detects it; a step releases it.
  assign core_en = (state == STEP) | ((state == RUN) & div_tick & ~bkpt_hit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      insn_cnt <= '0;
    end else if (core_en && bus.i_insn_vld && (insn_cnt != '1)) begin
      insn_cnt <= insn_cnt + CNT_W'(1);
    end
  end

  assign bus.o_core_en  = core_en;
  assign bus.o_halted   = (state == HALT) | (state == BREAK);
  assign bus.o_state    = state;
  assign bus.o_insn_cnt = insn_cnt;
endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: three instances (base, RUN_DIV=3, CNT_W=4) share
// one stimulus; table-driven run vectors plus hand-written step/breakpoint/reset sequences.
module tb_core_run_ctrl;
  logic        clk;
  logic        rst_n;
  logic        step_btn_n;
  logic        run_sw;
  logic [31:0] pc;
  logic        insn_vld;
  logic        bkpt_en;
  logic [31:0] bkpt_addr;

  int n_cmp;
  int n_bad;

  logic [31:0] exp_cnt;
  logic [31:0] exp_cnt_div;
  logic [3:0]  exp_cnt_sat;

  core_run_ctrl_if #(.CNT_W(32)) bus_a ();
  core_run_ctrl_if #(.CNT_W(32)) bus_b ();
  core_run_ctrl_if #(.CNT_W(4))  bus_c ();

  assign bus_a.i_step_btn_n = step_btn_n;
  assign bus_a.i_run_sw     = run_sw;
  assign bus_a.i_pc         = pc;
  assign bus_a.i_insn_vld   = insn_vld;
  assign bus_a.i_bkpt_en    = bkpt_en;
  assign bus_a.i_bkpt_addr  = bkpt_addr;
  assign bus_b.i_step_btn_n = step_btn_n;
  assign bus_b.i_run_sw     = run_sw;
  assign bus_b.i_pc         = pc;
  assign bus_b.i_insn_vld   = insn_vld;
  assign bus_b.i_bkpt_en    = bkpt_en;
  assign bus_b.i_bkpt_addr  = bkpt_addr;
  assign bus_c.i_step_btn_n = step_btn_n;
  assign bus_c.i_run_sw     = run_sw;
  assign bus_c.i_pc         = pc;
  assign bus_c.i_insn_vld   = insn_vld;
  assign bus_c.i_bkpt_en    = bkpt_en;
  assign bus_c.i_bkpt_addr  = bkpt_addr;

  core_run_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
  core_run_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(3), .CNT_W(32)) dut_div (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));
  core_run_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_c));

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run_sw;
    logic [1:0]  exp_state;
    logic        exp_en;
    logic        exp_en_div;
  } vec_t;

  vec_t tbl [0:10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the active edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press_btn(input int low_cycles, input int high_cycles,
                           output int n_en, output int n_en_div, output int n_en_sat,
                           output int n_bad_state);
    n_en = 0; n_en_div = 0; n_en_sat = 0; n_bad_state = 0;
    for (int i = 0; i < low_cycles + high_cycles; i++) begin
      tick();
      step_btn_n = (i < low_cycles) ? 1'b0 : 1'b1;
      #1;
      if (bus_a.o_core_en) begin
        n_en++;
        if (bus_a.o_state != 2'd1) n_bad_state++;
      end
      if (bus_b.o_core_en) n_en_div++;
      if (bus_c.o_core_en) n_en_sat++;
    end
  endtask

  function automatic logic [3:0] sat_add(input logic [3:0] a, input int inc);
    int s;
    s = int'(a) + inc;
    return (s > 15) ? 4'hF : 4'(s);
  endfunction

  initial begin
    int ne, ned, nes, nbs;
    int tot, tot_div, tot_sat;
    bit seen;
    n_cmp = 0; n_bad = 0;
    exp_cnt = 0; exp_cnt_div = 0; exp_cnt_sat = 0;

    tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd2, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 2'd2, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 2'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'd2, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b0};

    // Reset
    rst_n = 1'b0; step_btn_n = 1'b1; run_sw = 1'b0; pc = 32'h0;
    insn_vld = 1'b0; bkpt_en = 1'b0; bkpt_addr = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("reset_state",  bus_a.o_state, 2'd0);
    chk("reset_halted", bus_a.o_halted, 1'b1);
    chk("reset_en",     bus_a.o_core_en, 1'b0);
    chk("reset_cnt",    bus_a.o_insn_cnt, 32'd0);
    chk("reset_cnt_sat", bus_c.o_insn_cnt, 4'd0);
    repeat (3) tick();

    // Glitch then hold
    insn_vld = 1'b1;
    press_btn(2, 10, ne, ned, nes, nbs);
    chk("glitch_en", ne, 0);
    press_btn(20, 10, ne, ned, nes, nbs);
    chk("hold_en_count", ne, 1);
    chk("hold_en_state", nbs, 0);
    chk("hold_en_count_div", ned, 1);
    #1;
    chk("hold_end_state", bus_a.o_state, 2'd0);
    exp_cnt = exp_cnt + 1; exp_cnt_div = exp_cnt_div + 1; exp_cnt_sat = sat_add(exp_cnt_sat, 1);
    chk("hold_cnt", bus_a.o_insn_cnt, exp_cnt);

    // Run vectors (base and divided instance in parallel)
    pc = 32'h100;
    for (int i = 0; i <= 10; i++) begin
      tick();
      run_sw = tbl[i].run_sw;
      #1;
      chk($sformatf("run_state[%0d]", i), bus_a.o_state, tbl[i].exp_state);
      chk($sformatf("run_en[%0d]", i), bus_a.o_core_en, tbl[i].exp_en);
      chk($sformatf("run_en_div[%0d]", i), bus_b.o_core_en, tbl[i].exp_en_div);
      chk($sformatf("run_state_div[%0d]", i), bus_b.o_state, tbl[i].exp_state);
      chk($sformatf("run_halted[%0d]", i), bus_a.o_halted, tbl[i].exp_state == 2'd0);
      exp_cnt     = exp_cnt + 32'(tbl[i].exp_en);
      exp_cnt_div = exp_cnt_div + 32'(tbl[i].exp_en_div);
      exp_cnt_sat = sat_add(exp_cnt_sat, int'(tbl[i].exp_en));
    end
    chk("run_cnt",     bus_a.o_insn_cnt, exp_cnt);
    chk("run_cnt_div", bus_b.o_insn_cnt, exp_cnt_div);
    chk("run_cnt_sat", bus_c.o_insn_cnt, exp_cnt_sat);

    // Saturation: 20 steps
    tot = 0; tot_div = 0; tot_sat = 0;
    for (int k = 0; k < 20; k++) begin
      press_btn(8, 8, ne, ned, nes, nbs);
      tot += ne; tot_div += ned; tot_sat += nes;
      exp_cnt = exp_cnt + 1; exp_cnt_div = exp_cnt_div + 1; exp_cnt_sat = sat_add(exp_cnt_sat, 1);
    end
    chk("steps_en_total", tot, 20);
    chk("steps_en_total_sat", tot_sat, 20);
    chk("steps_cnt",     bus_a.o_insn_cnt, exp_cnt);
    chk("steps_cnt_div", bus_b.o_insn_cnt, exp_cnt_div);
    chk("sat_cnt",       bus_c.o_insn_cnt, 4'hF);

    // Breakpoint sequence on the base instance
    bkpt_en = 1'b1; bkpt_addr = 32'h10; pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      run_sw = 1'b1;
      #1;
      chk($sformatf("bk_pre_state[%0d]", i), bus_a.o_state, 2'd0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      pc = 32'(i * 4);
      #1;
      chk($sformatf("bk_run_en[%0d]", i), bus_a.o_core_en, 1'b1);
    end
    tick();
    pc = 32'h10;
    #1;
`ifdef RUN_CTRL_BKPT_EN
    chk("bk_hit_en", bus_a.o_core_en, 1'b0);
    chk("bk_hit_state", bus_a.o_state, 2'd2);
    tick();
    #1;
    chk("bk_break_state", bus_a.o_state, 2'd3);
    chk("bk_break_halted", bus_a.o_halted, 1'b1);
    chk("bk_break_en", bus_a.o_core_en, 1'b0);
    step_btn_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      #1;
      if (bus_a.o_core_en) begin
        seen = 1'b1;
        chk("bk_step_state", bus_a.o_state, 2'd1);
      end else if (bus_a.o_state != 2'd3) begin
        chk("bk_wait_state", bus_a.o_state, 2'd3);
      end
    end
    chk("bk_step_seen", seen, 1'b1);
    tick();
    pc = 32'h14;
    #1;
    chk("bk_after_step_state", bus_a.o_state, 2'd0);
    tick();
    #1;
    chk("bk_resume_state", bus_a.o_state, 2'd2);
    chk("bk_resume_en", bus_a.o_core_en, 1'b1);
    step_btn_n = 1'b1;
`else
    chk("nobk_en_at_addr", bus_a.o_core_en, 1'b1);
    chk("nobk_state_at_addr", bus_a.o_state, 2'd2);
    tick();
    pc = 32'h14;
    #1;
    chk("nobk_state_after", bus_a.o_state, 2'd2);
    chk("nobk_en_after", bus_a.o_core_en, 1'b1);
`endif
    tick();
    run_sw = 1'b0;
    repeat (3) tick();
    #1;
    chk("bk_drop_state", bus_a.o_state, 2'd0);
    chk("bk_drop_en", bus_a.o_core_en, 1'b0);
    repeat (10) tick();

    // Async reset in the middle of RUN
    bkpt_en = 1'b0; pc = 32'h20;
    tick();
    run_sw = 1'b1;
    repeat (3) tick();
    #1;
    chk("ar_pre_state", bus_a.o_state, 2'd2);
    chk("ar_pre_en", bus_a.o_core_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_en",      bus_a.o_core_en, 1'b0);
    chk("ar_state",   bus_a.o_state, 2'd0);
    chk("ar_halted",  bus_a.o_halted, 1'b1);
    chk("ar_cnt",     bus_a.o_insn_cnt, 32'd0);
    chk("ar_en_div",  bus_b.o_core_en, 1'b0);
    chk("ar_cnt_sat", bus_c.o_insn_cnt, 4'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_sw = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
